// File: rtl/sisd_alu_pkg.sv
// Shared definitions for the SISD integer ALU: function codes, default width, flag bundle.
package alu_pkg;

    localparam int ALU_WIDTH_DEFAULT = 8;
    localparam int ALU_FUNC_W        = 3;

    typedef enum logic [ALU_FUNC_W-1:0] {
        ALU_PASS = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_SUB  = 3'b010,
        ALU_AND  = 3'b011,
        ALU_OR   = 3'b100,
        ALU_XOR  = 3'b101,
        ALU_SHL  = 3'b110,
        ALU_SHR  = 3'b111
    } alu_func_e;

    typedef struct packed {
        logic zero;
        logic negative;
        logic overflow;
    } alu_flags_t;

    // ADD and SUB share one adder; only SUB needs the subtract control.
    function automatic logic func_is_sub(input logic [ALU_FUNC_W-1:0] func);
        return func == ALU_SUB;
    endfunction

endpackage

// File: rtl/sisd_alu_addsub.sv
// Combinational WIDTH+1-bit adder/subtractor shared by ADD and SUB.
// o_carry is the carry-out for add and the borrow for subtract.
module alu_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] ext_b;
    logic [WIDTH:0] ext_res;

    assign ext_a = {1'b0, i_a};
    assign ext_b = {1'b0, i_b};

    // With a zero-extended operand, bit WIDTH of the difference is set exactly when a < b.
    assign ext_res = i_sub ? (ext_a - ext_b) : (ext_a + ext_b);

    assign o_sum   = ext_res[WIDTH-1:0];
    assign o_carry = ext_res[WIDTH];

endmodule

// File: rtl/sisd_alu.sv
// Single-issue registered integer ALU: op mux, flags and output registers.
// Optional ALU_SATURATE_EN clamps ADD carry to all ones and SUB borrow to zero.
module sisd_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [WIDTH-1:0]      i_s1,
    input  logic [WIDTH-1:0]      i_s2,
    input  logic                  i_en,
    input  logic [ALU_FUNC_W-1:0] i_func,
    output logic [WIDTH-1:0]      o_result,
    output logic                  o_zero,
    output logic                  o_negative,
    output logic                  o_overflow
);

    alu_func_e        func;
    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic [WIDTH-1:0] and_bits;
    logic [WIDTH-1:0] or_bits;
    logic [WIDTH-1:0] xor_bits;
    logic [WIDTH:0]   ext_d;
    logic [WIDTH-1:0] result_d;
    alu_flags_t       flags_d;
    logic [WIDTH-1:0] result_q;
    alu_flags_t       flags_q;

    assign func = alu_func_e'(i_func);

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_a     (i_s1),
        .i_b     (i_s2),
        .i_sub   (func_is_sub(i_func)),
        .o_sum   (as_sum),
        .o_carry (as_carry)
    );

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_logic
            assign and_bits[gi] = i_s1[gi] & i_s2[gi];
            assign or_bits[gi]  = i_s1[gi] | i_s2[gi];
            assign xor_bits[gi] = i_s1[gi] ^ i_s2[gi];
        end
    endgenerate

    // Bit WIDTH of ext_d is the unsigned overflow indicator for every op.
    always_comb begin
        ext_d = '0;
        case (func)
            ALU_PASS: ext_d = {1'b0, i_s1};
            ALU_ADD:  ext_d = {as_carry, as_sum};
            ALU_SUB:  ext_d = {as_carry, as_sum};
            ALU_AND:  ext_d = {1'b0, and_bits};
            ALU_OR:   ext_d = {1'b0, or_bits};
            ALU_XOR:  ext_d = {1'b0, xor_bits};
            ALU_SHL:  ext_d = {i_s1, 1'b0};
            ALU_SHR:  ext_d = {i_s1[0], 1'b0, i_s1[WIDTH-1:1]};
            default:  ext_d = '0;
        endcase
    end

    always_comb begin
        result_d = ext_d[WIDTH-1:0];
`ifdef ALU_SATURATE_EN
        if (ext_d[WIDTH]) begin
            if (func == ALU_ADD) begin
                result_d = '1;
            end else if (func == ALU_SUB) begin
                result_d = '0;
            end
        end
`endif
    end

    // Flags follow the final (possibly saturated) result.
    always_comb begin
        flags_d          = '0;
        flags_d.zero     = (result_d == '0);
        flags_d.negative = result_d[WIDTH-1];
        flags_d.overflow = ext_d[WIDTH];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            result_q <= '0;
            flags_q  <= '0;
        end else if (i_en) begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign o_result   = result_q;
    assign o_zero     = flags_q.zero;
    assign o_negative = flags_q.negative;
    assign o_overflow = flags_q.overflow;

endmodule

// File: tb/tb_sisd_alu.sv
// Self-checking bench for sisd_alu (WIDTH=8): directed cases, exhaustive ADD, random ops vs model.
module tb_sisd_alu;

    logic       clk;
    logic       rst;
    logic [7:0] s1;
    logic [7:0] s2;
    logic       en;
    logic [2:0] func;
    logic [7:0] result;
    logic       zero;
    logic       negative;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // expected {result, zero, negative, overflow}; held across disabled cycles
    logic [10:0] exp_q;

    sisd_alu #(.WIDTH(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_s1       (s1),
        .i_s2       (s2),
        .i_en       (en),
        .i_func     (func),
        .o_result   (result),
        .o_zero     (zero),
        .o_negative (negative),
        .o_overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] observed();
        return {result, zero, negative, overflow};
    endfunction

    // Reference model from the arithmetic definitions of each operation.
    function automatic logic [10:0] model(input int f, input int a, input int b);
        int  r;
        bit  ovf;
        r   = 0;
        ovf = 0;
        case (f)
            0: r = a;
            1: begin
                ovf = (a + b) > 255;
                r   = (a + b) % 256;
`ifdef ALU_SATURATE_EN
                if (ovf) r = 255;
`endif
            end
            2: begin
                ovf = a < b;
                r   = (a - b + 256) % 256;
`ifdef ALU_SATURATE_EN
                if (ovf) r = 0;
`endif
            end
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: begin
                r   = (a * 2) % 256;
                ovf = a >= 128;
            end
            default: begin
                r   = a / 2;
                ovf = (a % 2) == 1;
            end
        endcase
        return {r[7:0], r == 0, r >= 128, ovf};
    endfunction

    task automatic op(input string tag, input logic [2:0] f, input logic [7:0] a,
                      input logic [7:0] b, input logic e, input bit verbose);
        @(negedge clk);
        func = f;
        s1   = a;
        s2   = b;
        en   = e;
        if (e) exp_q = model(int'(f), int'(a), int'(b));
        @(posedge clk);
        #1;
        check(tag, {21'd0, observed()}, {21'd0, exp_q});
        if (verbose)
            $display("%s: func=%0d en=%0b s1=%02h s2=%02h -> result=%02h z=%0b n=%0b v=%0b",
                     tag, f, e, a, b, result, zero, negative, overflow);
    endtask

    // Directed case: model check plus a check against hand-written constants.
    task automatic dir(input string tag, input logic [2:0] f, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] r, input logic z,
                       input logic n, input logic v);
        op(tag, f, a, b, 1'b1, 1'b1);
        check({tag, "_const"}, {21'd0, observed()}, {21'd0, r, z, n, v});
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        func  = '0;
        s1    = '0;
        s2    = '0;
        exp_q = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {21'd0, observed()}, 32'd0);
        $display("reset_state: result=%02h z=%0b n=%0b v=%0b", result, zero, negative, overflow);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset in the middle of a cycle, with an op pending.
        dir("pass_7f", 3'd0, 8'h7F, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        func = 3'd1; s1 = 8'hFF; s2 = 8'hFF; en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", {21'd0, observed()}, 32'd0);
        $display("async_reset: result=%02h z=%0b n=%0b v=%0b", result, zero, negative, overflow);
        @(posedge clk);
        #1;
        check("reset_held", {21'd0, observed()}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        exp_q = '0;
        op("after_reset_hold", 3'd1, 8'hFF, 8'hFF, 1'b0, 1'b1);

        // ADD / SUB / logic / shift directed cases
        dir("add_100_155", 3'd1, 8'd100, 8'd155, 8'd255, 1'b0, 1'b1, 1'b0);
`ifdef ALU_SATURATE_EN
        dir("add_200_100", 3'd1, 8'd200, 8'd100, 8'd255, 1'b0, 1'b1, 1'b1);
        dir("sub_3_5",     3'd2, 8'd3,   8'd5,   8'd0,   1'b1, 1'b0, 1'b1);
`else
        dir("add_200_100", 3'd1, 8'd200, 8'd100, 8'd44,  1'b0, 1'b0, 1'b1);
        dir("sub_3_5",     3'd2, 8'd3,   8'd5,   8'd254, 1'b0, 1'b1, 1'b1);
`endif
        dir("sub_5_5",     3'd2, 8'd5,   8'd5,   8'd0,   1'b1, 1'b0, 1'b0);
        dir("and_f0_3c",   3'd3, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0, 1'b0);
        dir("or_0f_30",    3'd4, 8'h0F,  8'h30,  8'h3F,  1'b0, 1'b0, 1'b0);
        dir("xor_ff_ff",   3'd5, 8'hFF,  8'hFF,  8'h00,  1'b1, 1'b0, 1'b0);
        dir("shl_81",      3'd6, 8'h81,  8'hAA,  8'h02,  1'b0, 1'b0, 1'b1);
        dir("shr_01",      3'd7, 8'h01,  8'h55,  8'h00,  1'b1, 1'b0, 1'b1);

        // Enable hold
        dir("hold_add_1_1", 3'd1, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            op("hold_en0", 3'd1, 8'hFF, 8'hFF, 1'b0, 1'b1);
            check("hold_const", {21'd0, observed()}, {21'd0, 8'd2, 3'b000});
        end

        // Back-to-back enabled ops
`ifdef ALU_SATURATE_EN
        dir("b2b_add_255_1", 3'd1, 8'hFF, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b1);
`else
        dir("b2b_add_255_1", 3'd1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
`endif
        dir("b2b_pass_80",   3'd0, 8'h80, 8'h00, 8'h80, 1'b0, 1'b1, 1'b0);

        // Exhaustive ADD
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                op("add_exh", 3'd1, a[7:0], b[7:0], 1'b1, 1'b0);
            end
        end
        $display("add_exhaustive: 65536 operand pairs applied");

        // Random ops with random enable
        for (int i = 0; i < 4000; i++) begin
            op("rand", 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
               1'($urandom_range(0, 4) != 0), 1'b0);
        end
        $display("random: 4000 operations applied");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sisd_alu.md
Name: sisd_alu

Overview:
- Single-issue integer ALU for the SISD datapath.
- Combines two WIDTH-bit operands with one of eight operations selected by i_func.
- Result and status flags (zero, negative, overflow/carry) are registered.
- Sits between the register-file read ports and the write-back/flag register.

Parameters:
- WIDTH, 8, operand/result width in bits (minimum 2).

Ports:
- i_clk  input  1  system clock, rising-edge active.
- i_rst  input  1  asynchronous, active-high reset.
- i_s1  input  WIDTH  source operand 1.
- i_s2  input  WIDTH  source operand 2.
- i_en  input  1  operation enable; outputs update only when high.
- i_func  input  3  operation select.
- o_result  output  WIDTH  registered result.
- o_zero  output  1  registered: result == 0.
- o_negative  output  1  registered: result MSB.
- o_overflow  output  1  registered: carry/borrow/shift-out indicator (unsigned overflow).

Behaviour:
- Reset: i_rst high asynchronously clears o_result, o_zero, o_negative and o_overflow to 0. This holds for the whole time reset is asserted, including mid-operation. There is no pending state.
- Latency: one cycle. Operands and func sampled at a rising i_clk with i_en=1 appear on the outputs after that edge.
- i_en=0: all outputs hold their previous values. Flags are never recomputed without en.
- Operations, computed internally at WIDTH+1 bits:
  - 000 PASS: result = s1; ovf = 0.
  - 001 ADD: {c,result} = s1 + s2; ovf = c. ovf=1 exactly when s1+s2 > 2^WIDTH-1. Wraps modulo 2^WIDTH.
  - 010 SUB: result = s1 - s2 mod 2^WIDTH; ovf = borrow (s1 < s2).
  - 011 AND, 100 OR, 101 XOR: bitwise; ovf = 0.
  - 110 SHL: result = s1 << 1; ovf = s1[MSB].
  - 111 SHR: logical right shift by 1; ovf = s1[0].
- Flags: o_zero = (result == 0); o_negative = result[WIDTH-1]. Both are derived from the final (post-saturation, if enabled) result.
- i_s2 is ignored for PASS, SHL and SHR.
- Outputs are glitch-free: register outputs only, with no combinational path from inputs to outputs.

Optional Feature:
- Macro ALU_SATURATE_EN.
- Defined:
  - ADD with carry yields result = all ones (255 for WIDTH=8).
  - SUB with borrow yields result = 0.
  - o_overflow is still set in both cases; zero/negative flags follow the saturated result.
- Undefined: ADD/SUB wrap modulo 2^WIDTH as above.

Decomposition:
- Shared package alu_pkg:
  - function-code constants (ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR).
  - default width constant.
- One sub-module, alu_addsub:
  - combinational WIDTH+1-bit adder/subtractor with a sub control input.
  - returns sum and carry/borrow, shared by ADD and SUB.
- Top module holds the op mux, flag logic, optional saturation and output registers.

Test Plan:
- Reset: assert i_rst asynchronously mid-cycle after a result of 0x7F -> all outputs 0 immediately, without waiting for a clock edge. Deassert -> outputs stay 0 until the next enabled op.
- Exhaustive ADD: i_func=001, i_en=1, every s1,s2 in 0..255, checked one cycle later:
  - o_result = (s1+s2) mod 256.
  - o_overflow = 1 iff s1+s2 > 255 (e.g. 200+100 -> 44, ovf=1; 100+155 -> 255, ovf=0, neg=1).
- SUB/flags: 5-5 -> result 0, zero=1, ovf=0; 3-5 -> 254, neg=1, ovf=1. With ALU_SATURATE_EN, 3-5 -> 0, zero=1, ovf=1.
- Logic/shift:
  - AND 0xF0,0x3C -> 0x30.
  - XOR 0xFF,0xFF -> 0, zero=1.
  - SHL 0x81 -> 0x02, ovf=1.
  - SHR 0x01 -> 0, zero=1, ovf=1.
- Enable hold: compute ADD 1+1 (result 2), then drop i_en and apply 255+255 for 3 cycles -> outputs remain 2 with all flags 0.
- Back-to-back: ADD 255+1 then PASS 0x80 on consecutive enabled cycles:
  - cycle 1: 0, zero=1, ovf=1.
  - cycle 2: 0x80, neg=1, ovf=0.
